// File: rtl/aes_pkg.sv
// Shared AES-128 types and helpers for the iterative encrypt/decrypt sequencers.
package aes_pkg;

  localparam int unsigned N       = 4;
  localparam int unsigned Nb      = 4;
  localparam int unsigned Nr      = 10;
  localparam int unsigned KeySize = N * N * 8;

  // Indexed as s[row][col], one byte per cell.
  typedef logic [N-1:0][Nb-1:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Column-major: byte 4c+r of the block (MSB first) lands in s[r][c].
  function automatic state_t to_state(input logic [KeySize-1:0] b);
    state_t s;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(Nb); c++) begin
        s[r][c] = b[KeySize-1-8*(4*c+r) -: 8];
      end
    end
    return s;
  endfunction

  function automatic logic [KeySize-1:0] from_state(input state_t s);
    logic [KeySize-1:0] b;
    b = '0;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(Nb); c++) begin
        b[KeySize-1-8*(4*c+r) -: 8] = s[r][c];
      end
    end
    return b;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254 (0 maps to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] inv;
    p   = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for round i (1..10): 01,02,04,...,1b,36.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < 10; j++) begin
      if (4'(j) < i) r = xtime(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/encrypt_sequencer_rounds.sv
// Combinational AES round datapaths shared by the iterative encrypt sequencer.
module encrypt_middle_round
  import aes_pkg::*;
(
  input  state_t     state_i,
  input  state_t     key_i,
  input  logic [3:0] round_i,
  output state_t     state_o,
  output state_t     key_next_o
);

  state_t         sb;
  state_t         sr;
  state_t         mc;
  state_t         kn;
  logic [3:0][7:0] t;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    kn = '0;
    t  = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sb[r][c] = sbox(state_i[r][c]);
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r][c] = sb[r][(c+r)%4];
      end
    end
    // MixColumns row r: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mc[r][c] = xtime(sr[r][c]) ^ xtime(sr[(r+1)%4][c]) ^ sr[(r+1)%4][c] ^
                   sr[(r+2)%4][c] ^ sr[(r+3)%4][c];
      end
    end
    // Next round key: RotWord/SubWord of the last column plus rcon of the next round.
    for (int r = 0; r < 4; r++) begin
      t[r] = sbox(key_i[(r+1)%4][3]);
    end
    t[0] = t[0] ^ rcon(4'(round_i + 4'd1));
    for (int r = 0; r < 4; r++) begin
      kn[r][0] = key_i[r][0] ^ t[r];
      for (int c = 1; c < 4; c++) begin
        kn[r][c] = key_i[r][c] ^ kn[r][c-1];
      end
    end
  end

  assign state_o    = (round_i == 4'd0) ? (state_i ^ key_i) : (mc ^ key_i);
  assign key_next_o = kn;

endmodule

// Last round: no MixColumns and no key schedule; the caller supplies round key 10.
module encrypt_final_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t key_i,
  output state_t state_o
);

  state_t sr;

  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r][c] = sbox(state_i[r][(c+r)%4]);
      end
    end
  end

  assign state_o = sr ^ key_i;

endmodule

// File: rtl/encrypt_sequencer.sv
// Iterative AES-128 encryption: one middle-round datapath reused for rounds 0..9,
// a final-round datapath for round 10, valid/ready on both sides.
module encrypt_sequencer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KeySize-1:0] plaintext,
  input  logic [KeySize-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KeySize-1:0] ciphertext,
  output logic               busy
);

  enc_state_e fsm_q, fsm_d;
  state_t     state_q, state_d;
  state_t     key_q, key_d;
  logic [3:0] rnd_q, rnd_d;

  state_t mid_state;
  state_t mid_key;
  state_t fin_state;
  logic   accept;

  encrypt_middle_round u_middle (
    .state_i    (state_q),
    .key_i      (key_q),
    .round_i    (rnd_q),
    .state_o    (mid_state),
    .key_next_o (mid_key)
  );

  encrypt_final_round u_final (
    .state_i (state_q),
    .key_i   (key_q),
    .state_o (fin_state)
  );

  assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = to_state(plaintext);
          key_d   = to_state(key);
          rnd_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (rnd_q < 4'(Nr)) begin
          state_d = mid_state;
          key_d   = mid_key;
          rnd_d   = 4'(rnd_q + 4'd1);
        end else if (rnd_q == 4'(Nr)) begin
          state_d = fin_state;
          fsm_d   = DONE;
        end else begin
          fsm_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_d = to_state(plaintext);
            key_d   = to_state(key);
            rnd_d   = '0;
            fsm_d   = RUN;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q == RUN);
  // Never expose a partially-encrypted state.
  assign ciphertext = (fsm_q == DONE) ? from_state(state_q) : '0;

endmodule
